// File: rtl/parallel_loader.sv
// parallel_loader: packs a stream of words into a NUM_ELEMENTS-wide vector.
// Frames end when the last slot is filled or when s_last arrives with an
// accepted word. Short frames are zero-padded on the copy into the output
// register, so the fill buffer itself never needs clearing.
//
// Handshake: a word transfers on every rising edge where s_valid && s_ready.
// s_ready is a registered signal that is 0 while rst is high and 1 from the
// first edge after rst deasserts. There is no downstream backpressure, so
// s_ready stays 1 for as long as the block is out of reset. out_valid is a
// one-cycle pulse with no ready; the consumer must take every vector.
module parallel_loader #(
    parameter int NUM_ELEMENTS = 256,
    parameter int DATA_WIDTH   = 32,
    parameter int LEN_WIDTH    = $clog2(NUM_ELEMENTS) + 1
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [DATA_WIDTH-1:0]                     s_data,
    input  logic                                      s_valid,
    input  logic                                      s_last,
    output logic                                      s_ready,
    output logic [NUM_ELEMENTS-1:0][DATA_WIDTH-1:0]   out_data,
    output logic                                      out_valid,
    output logic [LEN_WIDTH-1:0]                      out_len,
    output logic                                      o_dbg_state
);

    localparam int IDX_W = (NUM_ELEMENTS > 1) ? $clog2(NUM_ELEMENTS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEMENTS - 1);

    // RESET is held while rst is high; FILL is the only operating state and
    // a frame end is a FILL->FILL transition that rewinds the write index.
    typedef enum logic {
        ST_RESET = 1'b0,
        ST_FILL  = 1'b1
    } state_t;

    state_t                                  r_state;
    state_t                                  w_state_next;
    logic [IDX_W-1:0]                        r_wr_idx;
    logic [IDX_W-1:0]                        w_wr_idx_next;
    logic [DATA_WIDTH-1:0]                   r_fill [NUM_ELEMENTS];
    logic [NUM_ELEMENTS-1:0][DATA_WIDTH-1:0] r_out_data;
    logic                                    r_out_valid;
    logic [LEN_WIDTH-1:0]                    r_out_len;
    logic                                    w_ready;
    logic                                    w_accept;
    logic                                    w_frame_end;

    // State register: reset dominates, otherwise follow the next-state logic.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RESET;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state, acceptance and frame-end decode.
    always_comb begin
        w_state_next  = r_state;
        w_ready       = (r_state == ST_FILL);
        w_accept      = s_valid && w_ready;
        w_frame_end   = 1'b0;
        w_wr_idx_next = r_wr_idx;
        case (r_state)
            ST_RESET: begin
                w_state_next = ST_FILL;
            end
            ST_FILL: begin
                w_state_next = ST_FILL;
                if (w_accept) begin
                    // Full slot and s_last together still make one frame end.
                    if ((r_wr_idx == LAST_IDX) || s_last) begin
                        w_frame_end   = 1'b1;
                        w_wr_idx_next = '0;
                    end else begin
                        w_wr_idx_next = r_wr_idx + IDX_W'(1);
                    end
                end
            end
            default: begin
                w_state_next = ST_RESET;
            end
        endcase
    end

    // Write index: rewinds on reset so the next accepted word lands at slot 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_idx <= '0;
        end else begin
            r_wr_idx <= w_wr_idx_next;
        end
    end

    // Fill buffer: stale contents beyond the frame are masked on the copy.
    always_ff @(posedge clk) begin
        if (!rst && w_accept) begin
            r_fill[r_wr_idx] <= s_data;
        end
    end

    // Output register: loaded once per frame end, padded past the final word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_data  <= '0;
            r_out_len   <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= w_frame_end;
            if (w_frame_end) begin
                for (int j = 0; j < NUM_ELEMENTS; j++) begin
                    if (IDX_W'(j) < r_wr_idx) begin
                        r_out_data[j] <= r_fill[j];
                    end else if (IDX_W'(j) == r_wr_idx) begin
                        // The final word bypasses the fill buffer.
                        r_out_data[j] <= s_data;
                    end else begin
                        r_out_data[j] <= '0;
                    end
                end
                r_out_len <= LEN_WIDTH'(r_wr_idx) + LEN_WIDTH'(1);
            end
        end
    end

    assign s_ready     = w_ready;
    assign out_data    = r_out_data;
    assign out_valid   = r_out_valid;
    assign out_len     = r_out_len;
    assign o_dbg_state = (r_state == ST_FILL);

endmodule

// File: tb/tb_parallel_loader.sv
// Bench for parallel_loader: directed frames with hand-computed results plus a
// frame-level model (word queue -> padded vector, length and 40-bit sum)
// compared against the DUT on every cycle.
module tb_parallel_loader;

    localparam int N  = 256;
    localparam int W  = 32;
    localparam int LW = 9;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [W-1:0]         s_data = '0;
    logic                 s_valid = 1'b0;
    logic                 s_last = 1'b0;
    logic                 s_ready;
    logic [N-1:0][W-1:0]  out_data;
    logic                 out_valid;
    logic [LW-1:0]        out_len;
    logic                 o_dbg_state;

    parallel_loader #(
        .NUM_ELEMENTS(N),
        .DATA_WIDTH  (W),
        .LEN_WIDTH   (LW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_last     (s_last),
        .s_ready    (s_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_len    (out_len),
        .o_dbg_state(o_dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    int     n_checks = 0;
    int     n_fail   = 0;
    longint cyc      = 0;
    bit     chk_en   = 1'b0;

    // Model state
    logic [W-1:0]        cur_q[$];
    logic [39:0]         exp_q[$];
    logic [N-1:0][W-1:0] m_vec   = '0;
    logic [LW-1:0]       m_len   = '0;
    logic                m_pulse = 1'b0;
    logic                m_ready = 1'b0;
    longint              pulse_cyc[$];

    function automatic logic [39:0] vec_sum(input logic [N-1:0][W-1:0] v);
        logic [39:0] s;
        s = '0;
        for (int j = 0; j < N; j++) s = s + 40'(v[j]);
        return s;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Frame-level model: collects accepted words, and on frame end builds the
    // zero-padded vector the consumer must see in the following cycle.
    always @(posedge clk) begin
        logic [39:0] s;
        cyc = cyc + 1;
        if (rst) begin
            cur_q.delete();
            m_vec   = '0;
            m_len   = '0;
            m_pulse = 1'b0;
            m_ready = 1'b0;
        end else begin
            m_pulse = 1'b0;
            if (s_valid && m_ready) begin
                cur_q.push_back(s_data);
                if (s_last || cur_q.size() == N) begin
                    m_vec = '0;
                    s = '0;
                    foreach (cur_q[j]) begin
                        m_vec[j] = cur_q[j];
                        s = s + 40'(cur_q[j]);
                    end
                    m_len   = LW'(cur_q.size());
                    m_pulse = 1'b1;
                    exp_q.push_back(s);
                    cur_q.delete();
                end
            end
            m_ready = 1'b1;
        end
    end

    // Compare process: every cycle, on the falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("s_ready", 64'(s_ready), 64'(m_ready));
            check("dbg_fill", 64'(o_dbg_state), 64'(m_ready));
            check("out_valid", 64'(out_valid), 64'(m_pulse));
            check("out_len", 64'(out_len), 64'(m_len));
            n_checks++;
            if (out_data !== m_vec) begin
                n_fail++;
                for (int j = 0; j < N; j++) begin
                    if (out_data[j] !== m_vec[j]) begin
                        $display("FAIL out_data[%0d] got=%0h exp=%0h (cycle %0d)",
                                 j, out_data[j], m_vec[j], cyc);
                        break;
                    end
                end
            end
            if (out_valid === 1'b1) begin
                pulse_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sum_unexpected_pulse got=%0h exp=none", vec_sum(out_data));
                end else begin
                    check("sum", 64'(vec_sum(out_data)), 64'(exp_q.pop_front()));
                end
            end
        end
    end

    // Driver tasks: inputs change 1 time unit after the rising edge.
    task automatic send(input logic [W-1:0] d, input logic last);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            s_valid = 1'b0;
            s_last  = 1'($urandom_range(0, 1));
            s_data  = $urandom;
            @(posedge clk);
            #1;
        end
        s_last = 1'b0;
    endtask

    // Watchdog
    initial begin
        #1_000_000;
        n_fail++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Directed stimulus with hand-computed expectations
    initial begin
        int len;
        logic lst;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b1;
        check("reset_s_ready", 64'(s_ready), 64'(0));
        check("reset_out_valid", 64'(out_valid), 64'(0));
        check("reset_out_len", 64'(out_len), 64'(0));
        check("reset_out_sum", 64'(vec_sum(out_data)), 64'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("ready_after_reset", 64'(s_ready), 64'(1));

        // Full frame 1..256
        for (int i = 0; i < N; i++) send(W'(i + 1), 1'b0);
        check("full_valid", 64'(out_valid), 64'(1));
        check("full_len", 64'(out_len), 64'(256));
        check("full_sum", 64'(vec_sum(out_data)), 64'(32896));
        check("full_e0", 64'(out_data[0]), 64'(1));
        check("full_e127", 64'(out_data[127]), 64'(128));
        check("full_e255", 64'(out_data[255]), 64'(256));
        idle(1);
        check("full_pulse_one_cycle", 64'(out_valid), 64'(0));
        idle(1);

        // Short frame A..D
        send(32'hA, 1'b0);
        send(32'hB, 1'b0);
        send(32'hC, 1'b0);
        send(32'hD, 1'b1);
        check("short_valid", 64'(out_valid), 64'(1));
        check("short_len", 64'(out_len), 64'(4));
        check("short_sum", 64'(vec_sum(out_data)), 64'(46));
        check("short_e3", 64'(out_data[3]), 64'(13));
        check("short_e4_pad", 64'(out_data[4]), 64'(0));
        check("short_e255_pad", 64'(out_data[255]), 64'(0));
        idle(2);

        // Back-to-back full frames
        pulse_cyc.delete();
        for (int i = 0; i < 2 * N; i++) send($urandom, 1'b0);
        idle(2);
        check("b2b_pulses", 64'(pulse_cyc.size()), 64'(2));
        if (pulse_cyc.size() == 2)
            check("b2b_spacing", 64'(pulse_cyc[1] - pulse_cyc[0]), 64'(256));

        // Reset mid-frame
        pulse_cyc.delete();
        for (int i = 0; i < 100; i++) send($urandom, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_s_ready", 64'(s_ready), 64'(0));
        check("midrst_out_valid", 64'(out_valid), 64'(0));
        check("midrst_out_len", 64'(out_len), 64'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_ready_back", 64'(s_ready), 64'(1));
        for (int i = 0; i < N; i++) send(32'hFFFF_FFFF, 1'b0);
        check("midrst_len", 64'(out_len), 64'(256));
        check("midrst_sum", 64'(vec_sum(out_data)), 64'(40'hFF_FFFF_FF00));
        idle(2);
        check("midrst_pulses", 64'(pulse_cyc.size()), 64'(1));

        // s_last on the final slot: one pulse
        pulse_cyc.delete();
        for (int i = 0; i < N; i++) send(W'(2), (i == N - 1));
        check("last256_len", 64'(out_len), 64'(256));
        idle(2);
        check("last256_pulses", 64'(pulse_cyc.size()), 64'(1));

        // s_last on the first word, then back-to-back 1-word frames
        send(32'd7, 1'b1);
        check("first_e0", 64'(out_data[0]), 64'(7));
        check("first_e1", 64'(out_data[1]), 64'(0));
        check("first_len", 64'(out_len), 64'(1));
        send(32'd5, 1'b1);
        check("one_word_b2b_valid", 64'(out_valid), 64'(1));
        check("one_word_b2b_e0", 64'(out_data[0]), 64'(5));
        idle(2);

        // Random stalls and random frame lengths
        for (int f = 0; f < 100; f++) begin
            len = (f % 10 == 9) ? N : $urandom_range(1, 64);
            for (int k = 0; k < len; k++) begin
                lst = (k == len - 1) && ((len < N) || ($urandom_range(0, 1) == 1));
                send($urandom, lst);
                idle($urandom_range(0, 3));
            end
        end

        idle(4);
        check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/parallel_loader.md
# parallel_loader

Stream-to-vector packer that sits directly upstream of the `parallel` adder-tree stage. It accepts 32-bit words one per cycle over a valid/ready handshake and assembles them into a 256-element vector. When a frame completes, it presents the vector with a single-cycle `out_valid` pulse, matching the `parallel` input contract of `in_data` plus a one-cycle `in_valid`. Short frames, ended early with `s_last`, are zero-padded so the downstream sum stays correct.

## Interface
- `NUM_ELEMENTS`, default 256: number of vector elements per frame.
- `DATA_WIDTH`, default 32: width of each element.
- `LEN_WIDTH`, default `$clog2(NUM_ELEMENTS)+1` (9): width of `out_len`.

- `clk` input, 1 bit: single clock; all logic is on its rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `s_data` input, `DATA_WIDTH`: input word.
- `s_valid` input, 1 bit: `s_data` is valid.
- `s_last` input, 1 bit: the current word ends the frame early. Qualified by `s_valid`.
- `s_ready` output, 1 bit: block can accept a word.
- `out_data` output, `NUM_ELEMENTS`×`DATA_WIDTH` (packed `[NUM_ELEMENTS-1:0][DATA_WIDTH-1:0]`): assembled vector. Drives `parallel.in_data`.
- `out_valid` output, 1 bit: one-cycle pulse when a new vector is presented. Drives `parallel.in_valid`.
- `out_len` output, `LEN_WIDTH`: number of real (non-padded) words in the presented frame, range 1..`NUM_ELEMENTS`.

## Operation
- A word is accepted on any rising edge where `s_valid && s_ready`.
- Fill buffer: an internal `NUM_ELEMENTS`×`DATA_WIDTH` register array.
- Write index: counter `wr_idx`, range 0..`NUM_ELEMENTS`-1.
  - An accepted word is written to element `wr_idx`, then `wr_idx` increments.
- Frame end occurs on acceptance of a word where `wr_idx == NUM_ELEMENTS-1` or `s_last == 1`, whichever applies; both together is a single frame end.
- At frame end:
  - The output register is loaded from the fill buffer, including the final word.
  - Every element with index > final index is forced to 0 in the output register.
  - `out_len` is set to final index + 1.
  - `wr_idx` returns to 0.
  - Fill-buffer contents need not be cleared, because padding is applied on the copy.
- `out_data` and `out_len` hold their values until the next frame end. They never change mid-fill.
- There is no downstream backpressure: `parallel` accepts every `in_valid`. `s_ready` is therefore 1 at all times outside reset.
- States:
  - RESET: `rst` is high.
  - FILL: `wr_idx` advances on each accepted word.
  - FILL is left only for RESET.
  - Frame end is a FILL→FILL transition with `wr_idx` reset to 0.
- Reset values:
  - `s_ready` = 0
  - `out_valid` = 0
  - `out_data` = all zeros
  - `out_len` = 0
  - `wr_idx` = 0
- Reset mid-frame: the partial frame is discarded and no `out_valid` is generated for it. The next accepted word is stored at index 0.
- `s_last` without `s_valid` is ignored.
- `s_last` on the word at index `NUM_ELEMENTS-1` produces exactly one pulse with `out_len` = `NUM_ELEMENTS`.

## Timing
- `s_ready` is registered: 0 while `rst` is high, 1 from the first edge after `rst` deasserts.
- Latency: `out_valid` is high for exactly one cycle, starting the cycle after the edge that accepted the frame-end word.
  - `out_data` and `out_len` are valid in that same cycle.
- Throughput: one word per cycle, sustained across frame boundaries with no bubble.
  - The first word of frame N+1 may be accepted on the same edge where frame N's `out_valid` is high.
- Minimum spacing between `out_valid` pulses is 1 cycle, for back-to-back 1-word frames. `parallel` tolerates consecutive `in_valid`.
- Gaps in `s_valid` stall `wr_idx` without corrupting the frame.

## Test plan
- **Full frame:** 256 words with values 1..256, `s_valid` continuous, no `s_last`.
  - `out_valid` pulses 1 cycle after the 256th accept.
  - `out_data[j]` = j+1 and `out_len` = 256.
  - Downstream `parallel` `out_data` = 0x00_0000_8080 (32896).
- **Short frame:** words 0xA, 0xB, 0xC, 0xD with `s_last` on the 4th.
  - Elements 0..3 = A..D, elements 4..255 = 0, `out_len` = 4, sum = 0x2E.
- **Back-to-back:** two full frames with no gap and random data.
  - Two `out_valid` pulses exactly 256 cycles apart.
  - The second frame's word 0 is accepted in the cycle of the first pulse.
  - Each vector matches its frame; `out_data` is stable between pulses.
- **Reset mid-frame:** assert `rst` for 1 cycle after 100 accepted words, then send 256 words of 0xFFFFFFFF.
  - No pulse occurs for the partial frame.
  - The next pulse has all elements = 0xFFFFFFFF and `out_len` = 256.
  - `s_ready` = 0 during reset and returns to 1 the next cycle.
- **Edge cases:**
  - `s_last` on word 256 gives a single pulse with `out_len` = 256.
  - `s_last` on the first word (value 7) gives `out_data[0]` = 7, all other elements 0, `out_len` = 1.
- **Random stall:** 100 frames with `s_valid` randomly low for 0–3 cycles between words and random `s_last`.
  - A scoreboard of expected 40-bit sums matches `parallel` output for every frame.
